// File: rtl/fc_score_buffer.sv
// Final-layer score collector: bias-add, rescale and saturate one accumulator per channel,
// then stream the buffered scores as indexed pairs for the argmax stage.
module fc_score_buffer #(
  parameter int DATA_WIDTH     = 16,
  parameter int ACC_WIDTH      = 32,
  parameter int OUTPUT_CHANNEL = 10,
  parameter int FRAC_SHIFT     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [4:0]                   in_ch,
  input  logic signed [ACC_WIDTH-1:0]  in_acc,
  input  logic signed [DATA_WIDTH-1:0] in_bias,
  output logic signed [DATA_WIDTH-1:0] out_inp1,
  output logic signed [DATA_WIDTH-1:0] out_inp2,
  output logic [4:0]                   out_index,
  output logic                         out_valid,
  output logic                         frame_done,
  output logic                         err
);

  localparam int SW = ACC_WIDTH + FRAC_SHIFT + 1;
  localparam int CW = (OUTPUT_CHANNEL > 2) ? $clog2(OUTPUT_CHANNEL) : 1;
  localparam logic signed [SW-1:0] QMAX = (SW'(1) <<< (DATA_WIDTH-1)) - SW'(1);
  localparam logic signed [SW-1:0] QMIN = -(SW'(1) <<< (DATA_WIDTH-1));

  typedef enum logic [1:0] {COLLECT, STREAM, DONE} state_t;

  state_t                        state;
  logic signed [DATA_WIDTH-1:0]  mem [OUTPUT_CHANNEL];
  logic [OUTPUT_CHANNEL-1:0]     mask, mask_nxt;
  logic [5:0]                    k;
  logic signed [SW-1:0]          sum, q;
  logic signed [DATA_WIDTH-1:0]  sat;
  logic [CW-1:0]                 wa, r0, r1;
  logic                          ch_ok, bad, accept, wr;

  assign in_ready = (state == COLLECT);

  always_comb begin
    sum = SW'(in_acc) + (SW'(in_bias) <<< FRAC_SHIFT);
    q   = sum >>> FRAC_SHIFT;
    if (q > QMAX)      sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (q < QMIN) sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else               sat = q[DATA_WIDTH-1:0];
  end

  // Out-of-range channels never reach mask[wa]: the short-circuit hides the bogus read.
  assign wa       = in_ch[CW-1:0];
  assign ch_ok    = in_ch < 5'(OUTPUT_CHANNEL);
  assign bad      = !ch_ok || mask[wa];
  assign accept   = in_valid && in_ready;
  assign wr       = accept && !bad;
  assign mask_nxt = mask | (OUTPUT_CHANNEL'(1) << wa);

  // Beat 0 repeats the first pair so the argmax seeds from (s0,s1) before comparing.
  assign r0 = (k == 6'd0) ? '0 : CW'(k - 6'd2);
  assign r1 = r0 + CW'(1);

  always_ff @(posedge clk)
    if (wr) mem[wa] <= sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= COLLECT;
      mask       <= '0;
      k          <= '0;
      out_inp1   <= '0;
      out_inp2   <= '0;
      out_index  <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      err        <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        COLLECT: begin
          if (accept) begin
            if (bad) err <= 1'b1;
            else begin
              mask <= mask_nxt;
              if (&mask_nxt) begin
                state <= STREAM;
                k     <= '0;
              end
            end
          end
        end
        STREAM: begin
          if (k <= 6'(OUTPUT_CHANNEL)) begin
            out_inp1  <= mem[r0];
            out_inp2  <= mem[r1];
            out_index <= k[4:0];
            out_valid <= 1'b1;
            k         <= k + 6'd2;
          end else begin
            // Pair/index outputs hold so the argmax is not reseeded.
            out_valid  <= 1'b0;
            frame_done <= 1'b1;
            mask       <= '0;
            state      <= DONE;
          end
        end
        DONE:    state <= COLLECT;
        default: state <= COLLECT;
      endcase
    end
  end

endmodule
